// File: rtl/memory_stage_pkg.sv
// Shared definitions for the memory stage: MemWrite encodings, data-memory
// access FSM states and the default wait-cycle limit.
package memory_stage_pkg;

  localparam int TIMEOUT_DEFAULT = 16;

  // 1x patterns are HI/LO moves; they travel as ALU results and never touch memory.
  typedef enum logic [1:0] {
    MW_NONE     = 2'b00,
    MW_STORE    = 2'b01,
    MW_HILO     = 2'b10,
    MW_HILO_ALT = 2'b11
  } memWriteT;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } dmemStateT;

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory port of the memory stage.
interface memory_stage_if;

  // The master raises dmem_req and holds dmem_addr/dmem_we/dmem_wdata steady
  // until a cycle with dmem_ready=1, which completes the access; a load's
  // dmem_rdata is valid in that cycle. dmem_ready is ignored while dmem_req=0.
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ready
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ready
  );

endinterface

// File: rtl/memory_stage_dmem_access_fsm.sv
// Data-memory access sequencer: tracks outstanding wait states, generates the
// request and the pipeline stall, and abandons an access after TIMEOUT waits.
module dmem_access_fsm
  import memory_stage_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      memOp,
  input  logic      aligned,
  input  logic      dmemReady,
  output logic      dmemReq,
  output logic      stall,
  output logic      timeout,
  output dmemStateT state
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  dmemStateT     stateNext;
  logic [CW-1:0] waitCnt;
  logic [CW-1:0] cntNext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      waitCnt <= '0;
    end else begin
      state   <= stateNext;
      waitCnt <= cntNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = waitCnt;
    dmemReq   = 1'b0;
    timeout   = 1'b0;
    case (state)
      ST_IDLE: begin
        dmemReq = memOp & aligned;
        if (dmemReq && !dmemReady) begin
          stateNext = ST_WAIT;
          cntNext   = '0;
        end
      end
      ST_WAIT: begin
        // The request is withdrawn in the cycle the limit is reached, which releases the stall.
        if (waitCnt == TMAX) begin
          timeout   = 1'b1;
          stateNext = ST_IDLE;
        end else begin
          dmemReq = memOp & aligned;
          if (dmemReady) begin
            stateNext = ST_IDLE;
          end else begin
            cntNext = waitCnt + 1'b1;
          end
        end
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  assign stall = dmemReq & ~dmemReady;

endmodule

// File: rtl/memory_stage.sv
// Pipeline memory stage: EX/MEM register, data-memory access with wait states,
// timeout and misalignment handling, and the MEM/WB register feeding writeback.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RegWriteE,
  input  logic                 MemToRegE,
  input  logic [1:0]           MemWriteE,
  input  logic [31:0]          ALUOutE,
  input  logic [31:0]          WriteDataE,
  input  logic [4:0]           WriteRegE,
  input  logic                 MultStartE,
  input  logic                 MultComplete,
  memory_stage_if.master       dmem,
  output logic                 StallM,
  output logic [31:0]          ALUOutM,
  output logic [4:0]           WriteRegM,
  output logic                 RegWriteM,
  output logic                 RegWriteW,
  output logic [4:0]           WriteRegW,
  output logic [31:0]          ResultW,
  output logic [1:0]           mem_err,
  output dmemStateT            dbgState
);

  logic        MemToRegM;
  logic [1:0]  MemWriteM;
  logic [31:0] WriteDataM;
  logic        MemToRegW;
  logic [31:0] ALUOutW;
  logic [31:0] ReadDataW;

  logic bubbleE;
  logic storeM;
  logic memOpM;
  logic alignedM;
  logic dmemReq;
  logic timeoutM;

  assign bubbleE  = MultStartE & ~MultComplete;
  assign storeM   = (MemWriteM == MW_STORE);
  assign memOpM   = MemToRegM | storeM;
  assign alignedM = (ALUOutM[1:0] == 2'b00);

  // EX/MEM: an unfinished multiply enters M as a bubble with all controls cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWriteM  <= 1'b0;
      MemToRegM  <= 1'b0;
      MemWriteM  <= MW_NONE;
      ALUOutM    <= '0;
      WriteDataM <= '0;
      WriteRegM  <= '0;
    end else if (!StallM) begin
      RegWriteM  <= RegWriteE & ~bubbleE;
      MemToRegM  <= MemToRegE & ~bubbleE;
      MemWriteM  <= bubbleE ? MW_NONE : MemWriteE;
      ALUOutM    <= ALUOutE;
      WriteDataM <= WriteDataE;
      WriteRegM  <= WriteRegE;
    end
  end

  dmem_access_fsm #(.TIMEOUT(TIMEOUT)) u_access (
    .clk       (clk),
    .rst       (rst),
    .memOp     (memOpM),
    .aligned   (alignedM),
    .dmemReady (dmem.dmem_ready),
    .dmemReq   (dmemReq),
    .stall     (StallM),
    .timeout   (timeoutM),
    .state     (dbgState)
  );

  assign dmem.dmem_req   = dmemReq;
  assign dmem.dmem_we    = storeM;
  assign dmem.dmem_addr  = {ALUOutM[31:2], 2'b00};
  assign dmem.dmem_wdata = WriteDataM;

  // Load data is kept only from a completed request; misaligned and abandoned loads read as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWriteW <= 1'b0;
      MemToRegW <= 1'b0;
      WriteRegW <= '0;
      ALUOutW   <= '0;
      ReadDataW <= '0;
    end else if (StallM) begin
      RegWriteW <= 1'b0;
    end else begin
      RegWriteW <= RegWriteM;
      MemToRegW <= MemToRegM;
      WriteRegW <= WriteRegM;
      ALUOutW   <= ALUOutM;
      ReadDataW <= (dmemReq & dmem.dmem_ready) ? dmem.dmem_rdata : '0;
    end
  end

  assign ResultW = MemToRegW ? ReadDataW : ALUOutW;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_err <= 2'b00;
    end else begin
      if (memOpM && !alignedM) mem_err[0] <= 1'b1;
      if (timeoutM)            mem_err[1] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios plus a randomized
// instruction stream checked against a program-order reference model.
module tb_memory_stage;
  import memory_stage_pkg::*;

  localparam int TO = 16;
  localparam int N_RAND = 200;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        RegWriteE, MemToRegE, MultStartE, MultComplete;
  logic [1:0]  MemWriteE;
  logic [31:0] ALUOutE, WriteDataE;
  logic [4:0]  WriteRegE;
  logic        StallM, RegWriteM, RegWriteW;
  logic [31:0] ALUOutM, ResultW;
  logic [4:0]  WriteRegM, WriteRegW;
  logic [1:0]  mem_err;
  dmemStateT   dbgState;

  memory_stage_if dmemBus();

  memory_stage #(.TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .RegWriteE    (RegWriteE),
    .MemToRegE    (MemToRegE),
    .MemWriteE    (MemWriteE),
    .ALUOutE      (ALUOutE),
    .WriteDataE   (WriteDataE),
    .WriteRegE    (WriteRegE),
    .MultStartE   (MultStartE),
    .MultComplete (MultComplete),
    .dmem         (dmemBus),
    .StallM       (StallM),
    .ALUOutM      (ALUOutM),
    .WriteRegM    (WriteRegM),
    .RegWriteM    (RegWriteM),
    .RegWriteW    (RegWriteW),
    .WriteRegW    (WriteRegW),
    .ResultW      (ResultW),
    .mem_err      (mem_err),
    .dbgState     (dbgState)
  );

  int checks = 0;
  int failures = 0;

  // ---------------- memory responder ----------------
  logic        respEn = 1'b0;
  logic        manReady = 1'b0;
  logic [31:0] manRdata = '0;
  logic        respReady = 1'b0;
  logic [31:0] respRdata = '0;
  logic        respBusy = 1'b0;
  int          respWait = 0;
  logic [31:0] simMem[64];
  logic [31:0] refMem[64];

  logic [36:0] exp_q[$];
  logic [37:0] storeExp_q[$];
  logic [37:0] storeAct_q[$];

  assign dmemBus.dmem_ready = respEn ? respReady : manReady;
  assign dmemBus.dmem_rdata = respEn ? respRdata : manRdata;

  always @(posedge clk) begin
    #2;
    if (respEn) begin
      if (dmemBus.dmem_req) begin
        if (!respBusy) begin
          respBusy = 1'b1;
          respWait = $urandom_range(0, 3);
        end
        if (respWait == 0) begin
          respReady = 1'b1;
          respRdata = simMem[dmemBus.dmem_addr[7:2]];
          if (dmemBus.dmem_we) begin
            simMem[dmemBus.dmem_addr[7:2]] = dmemBus.dmem_wdata;
            storeAct_q.push_back({dmemBus.dmem_addr[7:2], dmemBus.dmem_wdata});
          end
          respBusy = 1'b0;
        end else begin
          respReady = 1'b0;
          respRdata = $urandom;
          respWait--;
        end
      end else begin
        respReady = 1'($urandom_range(0, 1));
        respRdata = $urandom;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_e(input logic rw, input logic mtr, input logic [1:0] mw,
                         input logic [31:0] alu, input logic [31:0] wd,
                         input logic [4:0] wr, input logic ms, input logic mc);
    RegWriteE    = rw;
    MemToRegE    = mtr;
    MemWriteE    = mw;
    ALUOutE      = alu;
    WriteDataE   = wd;
    WriteRegE    = wr;
    MultStartE   = ms;
    MultComplete = mc;
  endtask

  task automatic drive_nop();
    drive_e(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    drive_nop();
    manReady = 1'b0;
    manRdata = '0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (dmemBus.dmem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", dmemBus.dmem_req); end
    checks++; if (StallM !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", StallM); end
    checks++; if (RegWriteM !== 1'b0) begin failures++; $display("FAIL reset_regwritem got=%b exp=0", RegWriteM); end
    checks++; if (RegWriteW !== 1'b0) begin failures++; $display("FAIL reset_regwritew got=%b exp=0", RegWriteW); end
    checks++; if (mem_err !== 2'b00) begin failures++; $display("FAIL reset_memerr got=%b exp=00", mem_err); end
    checks++; if (dbgState !== ST_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dbgState, ST_IDLE); end
  endtask

  task automatic test_load_zero_wait();
    do_reset();
    manReady = 1'b1;
    manRdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    drive_e(1'b1, 1'b1, 2'b00, 32'h0000_0100, 32'h0, 5'd5, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive_nop();
    @(negedge clk);
    checks++; if (dmemBus.dmem_req !== 1'b1) begin failures++; $display("FAIL zw_req got=%b exp=1", dmemBus.dmem_req); end
    checks++; if (StallM !== 1'b0) begin failures++; $display("FAIL zw_stall got=%b exp=0", StallM); end
    checks++; if (dmemBus.dmem_addr !== 32'h100) begin failures++; $display("FAIL zw_addr got=%h exp=00000100", dmemBus.dmem_addr); end
    checks++; if (dmemBus.dmem_we !== 1'b0) begin failures++; $display("FAIL zw_we got=%b exp=0", dmemBus.dmem_we); end
    @(negedge clk);
    checks++; if (ResultW !== 32'hDEADBEEF) begin failures++; $display("FAIL zw_result got=%h exp=deadbeef", ResultW); end
    checks++; if (RegWriteW !== 1'b1) begin failures++; $display("FAIL zw_regwritew got=%b exp=1", RegWriteW); end
    checks++; if (WriteRegW !== 5'd5) begin failures++; $display("FAIL zw_writereg got=%0d exp=5", WriteRegW); end
  endtask

  task automatic test_store_wait();
    logic [31:0] wd;
    do_reset();
    wd = $urandom;
    manReady = 1'b0;
    @(posedge clk); #1;
    drive_e(1'b0, 1'b0, 2'b01, 32'h0000_0204, wd, 5'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive_nop();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (StallM !== 1'b1) begin failures++; $display("FAIL st_stall%0d got=%b exp=1", i, StallM); end
      checks++; if (dmemBus.dmem_addr !== 32'h204) begin failures++; $display("FAIL st_addr%0d got=%h exp=00000204", i, dmemBus.dmem_addr); end
      checks++; if (dmemBus.dmem_wdata !== wd) begin failures++; $display("FAIL st_wdata%0d got=%h exp=%h", i, dmemBus.dmem_wdata, wd); end
      checks++; if (dmemBus.dmem_we !== 1'b1) begin failures++; $display("FAIL st_we%0d got=%b exp=1", i, dmemBus.dmem_we); end
      checks++; if (RegWriteW !== 1'b0) begin failures++; $display("FAIL st_regwritew%0d got=%b exp=0", i, RegWriteW); end
      if (i == 1) begin
        checks++; if (dbgState !== ST_WAIT) begin failures++; $display("FAIL st_state got=%0d exp=%0d", dbgState, ST_WAIT); end
      end
      @(posedge clk); #1;
    end
    manReady = 1'b1;
    @(negedge clk);
    checks++; if (StallM !== 1'b0) begin failures++; $display("FAIL st_release got=%b exp=0", StallM); end
    checks++; if (dmemBus.dmem_req !== 1'b1) begin failures++; $display("FAIL st_req_done got=%b exp=1", dmemBus.dmem_req); end
    @(posedge clk); #1;
    manReady = 1'b0;
    @(negedge clk);
    checks++; if (dmemBus.dmem_req !== 1'b0) begin failures++; $display("FAIL st_req_after got=%b exp=0", dmemBus.dmem_req); end
  endtask

  // Stall covers the first request cycle plus TO cycles spent counting in WAIT.
  task automatic test_timeout();
    int stallCnt;
    logic seenEnd;
    do_reset();
    manReady = 1'b0;
    @(posedge clk); #1;
    drive_e(1'b1, 1'b1, 2'b00, 32'h0000_0040, 32'h0, 5'd7, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive_nop();
    stallCnt = 0;
    seenEnd = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!StallM) begin
        seenEnd = 1'b1;
        break;
      end
      stallCnt++;
    end
    checks++; if (seenEnd !== 1'b1) begin failures++; $display("FAIL to_release got=%b exp=1 (stall never released)", seenEnd); end
    checks++; if (stallCnt != TO + 1) begin failures++; $display("FAIL to_stall_cycles got=%0d exp=%0d", stallCnt, TO + 1); end
    checks++; if (dmemBus.dmem_req !== 1'b0) begin failures++; $display("FAIL to_req got=%b exp=0", dmemBus.dmem_req); end
    @(negedge clk);
    checks++; if (mem_err !== 2'b10) begin failures++; $display("FAIL to_memerr got=%b exp=10", mem_err); end
    checks++; if (ResultW !== 32'h0) begin failures++; $display("FAIL to_result got=%h exp=00000000", ResultW); end
    checks++; if (RegWriteW !== 1'b1) begin failures++; $display("FAIL to_regwritew got=%b exp=1", RegWriteW); end
    checks++; if (WriteRegW !== 5'd7) begin failures++; $display("FAIL to_writereg got=%0d exp=7", WriteRegW); end
  endtask

  task automatic test_misaligned_store();
    do_reset();
    manReady = 1'b0;
    @(posedge clk); #1;
    drive_e(1'b0, 1'b0, 2'b01, 32'h0000_0102, 32'h1234_5678, 5'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive_nop();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (dmemBus.dmem_req !== 1'b0) begin failures++; $display("FAIL mis_req%0d got=%b exp=0", i, dmemBus.dmem_req); end
      checks++; if (StallM !== 1'b0) begin failures++; $display("FAIL mis_stall%0d got=%b exp=0", i, StallM); end
    end
    checks++; if (mem_err !== 2'b01) begin failures++; $display("FAIL mis_memerr got=%b exp=01", mem_err); end
  endtask

  // Runs straight after the misaligned test so mem_err is non-zero going in.
  task automatic test_reset_mid_wait();
    manReady = 1'b0;
    @(posedge clk); #1;
    drive_e(1'b1, 1'b1, 2'b00, 32'h0000_0080, 32'h0, 5'd3, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive_nop();
    repeat (3) @(negedge clk);
    checks++; if (StallM !== 1'b1) begin failures++; $display("FAIL rmw_pre_stall got=%b exp=1", StallM); end
    checks++; if (dbgState !== ST_WAIT) begin failures++; $display("FAIL rmw_pre_state got=%0d exp=%0d", dbgState, ST_WAIT); end
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    checks++; if (dmemBus.dmem_req !== 1'b0) begin failures++; $display("FAIL rmw_req got=%b exp=0", dmemBus.dmem_req); end
    checks++; if (StallM !== 1'b0) begin failures++; $display("FAIL rmw_stall got=%b exp=0", StallM); end
    checks++; if (dbgState !== ST_IDLE) begin failures++; $display("FAIL rmw_state got=%0d exp=%0d", dbgState, ST_IDLE); end
    checks++; if (mem_err !== 2'b00) begin failures++; $display("FAIL rmw_memerr got=%b exp=00", mem_err); end
    checks++; if (RegWriteM !== 1'b0) begin failures++; $display("FAIL rmw_regwritem got=%b exp=0", RegWriteM); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mult_bubbles();
    do_reset();
    manReady = 1'b0;
    for (int i = 0; i < 31; i++) begin
      @(posedge clk); #1;
      drive_e(1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC,
              $urandom, 5'($urandom_range(1, 31)), 1'b1, 1'b0);
      @(negedge clk);
      checks++; if (RegWriteM !== 1'b0) begin failures++; $display("FAIL mult_bubble_m%0d got=%b exp=0", i, RegWriteM); end
      checks++; if (StallM !== 1'b0) begin failures++; $display("FAIL mult_bubble_stall%0d got=%b exp=0", i, StallM); end
      if (i >= 2) begin
        checks++; if (RegWriteW !== 1'b0) begin failures++; $display("FAIL mult_bubble_w%0d got=%b exp=0", i, RegWriteW); end
      end
    end
    @(posedge clk); #1;
    drive_e(1'b1, 1'b0, 2'b00, 32'h0000_0F00, 32'h0, 5'd9, 1'b1, 1'b1);
    @(posedge clk); #1;
    drive_nop();
    @(negedge clk);
    checks++; if (RegWriteM !== 1'b1) begin failures++; $display("FAIL mult_done_m got=%b exp=1", RegWriteM); end
    checks++; if (ALUOutM !== 32'h0000_0F00) begin failures++; $display("FAIL mult_aluoutm got=%h exp=00000f00", ALUOutM); end
    checks++; if (WriteRegM !== 5'd9) begin failures++; $display("FAIL mult_writeregm got=%0d exp=9", WriteRegM); end
    @(negedge clk);
    checks++; if (ResultW !== 32'h0000_0F00) begin failures++; $display("FAIL mult_result got=%h exp=00000f00", ResultW); end
    checks++; if (RegWriteW !== 1'b1) begin failures++; $display("FAIL mult_regwritew got=%b exp=1", RegWriteW); end
    checks++; if (WriteRegW !== 5'd9) begin failures++; $display("FAIL mult_writeregw got=%0d exp=9", WriteRegW); end
  endtask

  // Random instruction stream; the reference interprets each accepted instruction in program order.
  task automatic test_random();
    int issued = 0;
    int cycles = 0;
    int tail = 0;
    logic stallSeen = 1'b0;
    logic [36:0] e;
    do_reset();
    for (int i = 0; i < 64; i++) begin
      simMem[i] = $urandom;
      refMem[i] = simMem[i];
    end
    respBusy = 1'b0;
    respEn = 1'b1;
    while ((issued < N_RAND || tail < 30) && cycles < 4000) begin
      @(posedge clk); #1;
      if (!stallSeen) begin
        if (issued < N_RAND) begin
          int kind;
          logic [5:0] idx;
          logic [1:0] off;
          logic [31:0] alu, wd;
          logic [4:0] wr;
          logic rw, mtr, ms, mc, squash;
          logic [1:0] mw;
          kind = $urandom_range(0, 3);
          idx  = 6'($urandom_range(0, 63));
          off  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
          wd   = $urandom;
          wr   = 5'($urandom_range(0, 31));
          ms   = ($urandom_range(0, 7) == 0);
          mc   = 1'($urandom_range(0, 1));
          alu  = (kind == 1 || kind == 2) ? {22'h0, idx, off} : $urandom;
          rw   = (kind != 2);
          mtr  = (kind == 1);
          mw   = (kind == 2) ? 2'b01 : (kind == 3) ? {1'b1, 1'($urandom_range(0, 1))} : 2'b00;
          squash = ms && !mc;
          drive_e(rw, mtr, mw, alu, wd, wr, ms, mc);
          if (!squash) begin
            if (kind == 1) exp_q.push_back({wr, (off != 0) ? 32'h0 : refMem[idx]});
            else if (rw) exp_q.push_back({wr, alu});
            if (kind == 2 && off == 0) begin
              refMem[idx] = wd;
              storeExp_q.push_back({idx, wd});
            end
          end
          issued++;
        end else begin
          drive_nop();
        end
      end
      @(negedge clk);
      stallSeen = StallM;
      cycles++;
      if (issued >= N_RAND) tail++;
      if (RegWriteW) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rand_unexpected_wb got=reg%0d/%h exp=none", WriteRegW, ResultW);
        end else begin
          e = exp_q.pop_front();
          if ({WriteRegW, ResultW} !== e) begin
            failures++;
            $display("FAIL rand_wb got=reg%0d/%h exp=reg%0d/%h", WriteRegW, ResultW, e[36:32], e[31:0]);
          end
        end
      end
    end
    respEn = 1'b0;
    checks++; if (cycles >= 4000) begin failures++; $display("FAIL rand_cycle_budget got=%0d exp<4000", cycles); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rand_missing_wb got=%0d pending exp=0", exp_q.size()); end
    checks++;
    if (storeAct_q.size() != storeExp_q.size()) begin
      failures++;
      $display("FAIL rand_store_count got=%0d exp=%0d", storeAct_q.size(), storeExp_q.size());
    end else begin
      for (int i = 0; i < storeExp_q.size(); i++) begin
        checks++;
        if (storeAct_q[i] !== storeExp_q[i]) begin
          failures++;
          $display("FAIL rand_store%0d got=%h exp=%h", i, storeAct_q[i], storeExp_q[i]);
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    drive_nop();
    test_reset();
    test_load_zero_wait();
    test_store_wait();
    test_timeout();
    test_misaligned_store();
    test_reset_mid_wait();
    test_mult_bubbles();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter TIMEOUT, default 16, maximum dmem wait cycles before an access is abandoned.
REQ-002 clk  in  1  single pipeline clock; every register updates on its rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 RegWriteE  in  1  register-write flag leaving execute.
REQ-005 MemToRegE  in  1  load flag leaving execute.
REQ-006 MemWriteE  in  2  01 = store; 1x = HI/LO move (never touches memory); 00 = none.
REQ-007 ALUOutE  in  32  ALU/multiplier result; address for loads and stores.
REQ-008 WriteDataE  in  32  forwarded store data.
REQ-009 WriteRegE  in  5  destination register.
REQ-010 MultStartE  in  1  multiply in progress in execute.
REQ-011 MultComplete  in  1  multiplier finished this cycle.
REQ-012 dmem_rdata  in  32  load data, valid when dmem_ready=1.
REQ-013 dmem_ready  in  1  memory accepts/completes the current request.
REQ-014 dmem_req  out  1  access request.
REQ-015 dmem_we  out  1  1 = write.
REQ-016 dmem_addr  out  32  word address, {ALUOutM[31:2],2'b00}.
REQ-017 dmem_wdata  out  32  store data.
REQ-018 StallM  out  1  M stage holding; upstream stages freeze.
REQ-019 ALUOutM  out  32  registered M-stage result, for forwarding.
REQ-020 WriteRegM  out  5  registered M-stage destination.
REQ-021 RegWriteM  out  1  registered M-stage write flag.
REQ-022 RegWriteW  out  1  writeback enable.
REQ-023 WriteRegW  out  5  writeback destination.
REQ-024 ResultW  out  32  MemToRegW ? ReadDataW : ALUOutW (combinational).
REQ-025 mem_err  out  2  sticky flags: [0] misaligned access, [1] timeout.

Function
REQ-026 EX/MEM register SHALL hold when StallM=1; otherwise it SHALL capture all E inputs.
REQ-027 When MultStartE=1 and MultComplete=0, EX/MEM SHALL capture a bubble (RegWrite, MemToReg, MemWrite = 0).
REQ-028 memop = MemToRegM | (MemWriteM==01); HI/LO moves SHALL pass through as ALU results.
REQ-029 FSM states: IDLE, WAIT. IDLE->WAIT when memop, aligned, dmem_ready=0. WAIT->IDLE on dmem_ready or timeout.
REQ-030 dmem_req SHALL equal memop & aligned & (state!=WAIT or counter<TIMEOUT); dmem_we = store; address and data held stable while req=1.
REQ-031 A zero-wait access (dmem_ready=1 in the first req cycle) SHALL complete without stalling.
REQ-032 StallM SHALL equal dmem_req & ~dmem_ready.
REQ-033 Wait counter SHALL clear on entering WAIT and increment each WAIT cycle; at counter==TIMEOUT the access SHALL be abandoned, mem_err[1] set, load data forced to 0, and StallM released.
REQ-034 Misaligned memop (ALUOutM[1:0]!=0): no request, no stall, store suppressed, load result 0, mem_err[0] set.
REQ-035 MEM/WB SHALL capture a bubble (RegWriteW=0) while StallM=1; otherwise it SHALL capture M controls, ALUOutM, and dmem_rdata (load) on completion.
REQ-036 Load-to-writeback latency SHALL be one cycle after dmem_ready.

Reset
REQ-037 rst SHALL asynchronously clear all pipeline registers, state to IDLE, counter to 0, mem_err to 00, and force dmem_req, StallM, RegWriteM, RegWriteW to 0; an in-flight access is dropped.

Structure
REQ-038 The FSM state enum, MemWrite encodings, and TIMEOUT default SHALL live in the shared cpu package.
REQ-039 A sub-module dmem_access_fsm (IDLE/WAIT, counter, req/stall generation) SHALL be instantiated once; both pipeline registers stay in memory_stage.

Verification
REQ-040 Load at 0x100, dmem_ready=1 immediately, rdata 0xDEADBEEF -> no stall; next cycle ResultW=0xDEADBEEF, RegWriteW=1.
REQ-041 Store at 0x204 with 3 wait cycles -> StallM=1 for 3 cycles; addr/wdata/we stable; RegWriteW=0 during stall.
REQ-042 Load with dmem_ready held 0 -> 16 wait cycles then StallM=0, mem_err=10, ResultW=0.
REQ-043 Store at 0x102 -> dmem_req never asserted, mem_err=01, no stall.
REQ-044 MultStartE=1 for 32 cycles, MultComplete on cycle 32 -> bubbles in M until completion, then result 0x0000_0F00 reaches ResultW.
REQ-045 rst asserted mid-WAIT -> dmem_req and StallM drop the same cycle; state IDLE; mem_err=00.
